resilient_stage_ctrl: RTL and testbench

Synchronous sequencer for one timing-resilient pipeline stage. Accepts a token on the left four-phase handshake and pulses goml to capture it in the master latch. It then times the nominal delay, enables the error-detect window and reads the dual-rail error result (err1/err0). On error it stretches the cycle by a recovery interval; it then issues the right four-phase request. It is the clocked counterpart of the combinational clk/goML logic in the stage controllers and owns the sequencing of goml, re_en and rreq.

---
 rtl/resilient_stage_ctrl.sv | 175 +++++++++++++++++
 tb/tb_resilient_stage_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/resilient_stage_ctrl.sv
// resilient_stage_ctrl: clocked sequencer for one timing-resilient pipeline stage.
// It captures a token from the left four-phase handshake and pulses goml to load the master latch.
// It times the nominal stage delay, opens the error-detect window, and reads the dual-rail error result.
// On a detected error it stretches the cycle by a recovery interval, then runs the right four-phase handshake.
module resilient_stage_ctrl #(
    parameter int unsigned DELAY_CYC = 4,
    parameter int unsigned EXT_CYC   = 2,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lreq,
    output logic             lack,
    output logic             rreq,
    input  logic             rack,
    input  logic             err1,
    input  logic             err0,
    output logic             re_en,
    output logic             goml,
    output logic [CNT_W-1:0] err_cnt,
    output logic             viol,
    output logic             busy
);

    // Both interval timers are at most 15 cycles, so a 4-bit down-counter covers them.
    localparam int unsigned TMR_W = 4;
    localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] EXT_LOAD = TMR_W'(EXT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Reject parameter values outside their legal ranges when the design is elaborated.
    if (DELAY_CYC == 0 || DELAY_CYC > 15) begin : g_bad_delay
        $error("resilient_stage_ctrl: DELAY_CYC=%0d outside 1..15", DELAY_CYC);
    end
    if (EXT_CYC == 0 || EXT_CYC > 15) begin : g_bad_ext
        $error("resilient_stage_ctrl: EXT_CYC=%0d outside 1..15", EXT_CYC);
    end
    if (CNT_W == 0) begin : g_bad_cnt
        $error("resilient_stage_ctrl: CNT_W must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_DELAY   = 3'd2,
        S_SAMPLE  = 3'd3,
        S_EXTEND  = 3'd4,
        S_REQ     = 3'd5,
        S_REQ_RTZ = 3'd6
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_lack;
    logic               r_rreq;
    logic               r_re_en;
    logic               r_goml;
    logic               r_busy;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_viol;

    logic               w_err_event;
    logic               w_dual_rail_bad;
    logic               w_stray_rack;

    // Error-side events: both rails set is illegal but is still treated as an error.
    assign w_err_event     = (r_state == S_SAMPLE) && err1;
    assign w_dual_rail_bad = (r_state == S_SAMPLE) && err1 && err0;
    // rack is only meaningful while the right handshake is in flight.
    assign w_stray_rack    = rack && (r_state != S_REQ) && (r_state != S_REQ_RTZ);

    // Stage sequencer: state, interval timer, and every handshake/strobe output registered together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_lack  <= 1'b0;
            r_rreq  <= 1'b0;
            r_re_en <= 1'b0;
            r_goml  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_goml  <= 1'b0;
            r_re_en <= 1'b0;
            // The left return-to-zero is honoured in every state.
            if (!lreq) begin
                r_lack <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    // lack still high means the previous token has not seen lreq fall yet.
                    if (lreq && !r_lack) begin
                        r_state <= S_CAPTURE;
                        r_goml  <= 1'b1;
                        r_lack  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_tmr   <= DLY_LOAD;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_DELAY;
                end
                S_DELAY: begin
                    if (r_tmr == '0) begin
                        r_state <= S_SAMPLE;
                        r_re_en <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (err1) begin
                        r_state <= S_EXTEND;
                        r_tmr   <= EXT_LOAD;
                    end else if (err0) begin
                        r_state <= S_REQ;
                        r_rreq  <= 1'b1;
                    end else begin
                        // Result not resolved yet: keep the window open.
                        r_re_en <= 1'b1;
                    end
                end
                S_EXTEND: begin
                    if (r_tmr == '0) begin
                        r_state <= S_REQ;
                        r_rreq  <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr - TMR_W'(1);
                    end
                end
                S_REQ: begin
                    if (rack) begin
                        r_state <= S_REQ_RTZ;
                        r_rreq  <= 1'b0;
                    end
                end
                S_REQ_RTZ: begin
                    if (!rack) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rreq  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating error counter and sticky protocol-violation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
            r_viol    <= 1'b0;
        end else begin
            if (w_err_event && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_dual_rail_bad || w_stray_rack) begin
                r_viol <= 1'b1;
            end
        end
    end

    assign lack    = r_lack;
    assign rreq    = r_rreq;
    assign re_en   = r_re_en;
    assign goml    = r_goml;
    assign busy    = r_busy;
    assign err_cnt = r_err_cnt;
    assign viol    = r_viol;

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Scoreboard bench for resilient_stage_ctrl: the stimulus process queues the expected per-token outcome.
// A monitor measures each token and checks it when rreq rises.
module tb_resilient_stage_ctrl;

    localparam int unsigned DELAY_CYC = 4;
    localparam int unsigned EXT_CYC   = 2;
    localparam int unsigned CNT_W     = 2;

    logic             clk;
    logic             rst;
    logic             lreq;
    logic             lack;
    logic             rreq;
    logic             rack;
    logic             err1;
    logic             err0;
    logic             re_en;
    logic             goml;
    logic [CNT_W-1:0] err_cnt;
    logic             viol;
    logic             busy;

    resilient_stage_ctrl #(
        .DELAY_CYC (DELAY_CYC),
        .EXT_CYC   (EXT_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lreq    (lreq),
        .lack    (lack),
        .rreq    (rreq),
        .rack    (rack),
        .err1    (err1),
        .err0    (err0),
        .re_en   (re_en),
        .goml    (goml),
        .err_cnt (err_cnt),
        .viol    (viol),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lat;
        int re_cycles;
        int cnt;
        int viol;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   goml_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bounded wait on a DUT output, sampled on the falling edge.
    task automatic wait_for(input int sel, input logic val, input string name);
        logic cur;
        for (int i = 0; i < 200; i++) begin
            case (sel)
                0:       cur = lack;
                1:       cur = rreq;
                2:       cur = re_en;
                default: cur = goml;
            endcase
            if (cur == val) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s: signal never reached %0b", name, val);
    endtask

    // One left-to-right token; the expected measurements are queued before stimulus begins.
    task automatic token(input logic e1, input logic e0, input int unres, input bit stray,
                         input bit hold_lreq, input int exp_lat, input int exp_re,
                         input int exp_cnt, input int exp_viol);
        exp_t e;
        e.lat = exp_lat; e.re_cycles = exp_re; e.cnt = exp_cnt; e.viol = exp_viol;
        q.push_back(e);
        @(negedge clk);
        lreq = 1'b1;
        if (unres > 0) begin
            err1 = 1'b0; err0 = 1'b0;
        end else begin
            err1 = e1; err0 = e0;
        end
        wait_for(0, 1'b1, "lack_rise");
        if (stray) begin
            @(negedge clk);
            rack = 1'b1;
            @(negedge clk);
            rack = 1'b0;
        end
        if (unres > 0) begin
            wait_for(2, 1'b1, "re_en_rise");
            repeat (unres) @(negedge clk);
            err1 = e1; err0 = e0;
        end
        wait_for(1, 1'b1, "rreq_rise");
        rack = 1'b1;
        wait_for(1, 1'b0, "rreq_fall");
        rack = 1'b0;
        err1 = 1'b0; err0 = 1'b0;
        if (!hold_lreq) begin
            lreq = 1'b0;
            wait_for(0, 1'b0, "lack_fall");
        end
        repeat (2) @(negedge clk);
        chk("busy_after_token", int'(busy), 0);
    endtask

    // Monitor: measures goml width, re_en window and capture-to-rreq latency per token.
    initial begin
        int   cyc = 0;
        int   goml_start = 0;
        int   goml_len = 0;
        int   re_cnt = 0;
        logic goml_prev = 1'b0;
        logic rreq_prev = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                goml_prev = 1'b0;
                rreq_prev = 1'b0;
                continue;
            end
            if (goml && !goml_prev) begin
                goml_start = cyc;
                goml_len   = 0;
                re_cnt     = 0;
                goml_total++;
            end
            if (goml) goml_len++;
            if (re_en) re_cnt++;
            if (rreq && !rreq_prev) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rreq: got rreq with no queued token");
                end else begin
                    e = q.pop_front();
                    chk("latency_goml_to_rreq", cyc - goml_start, e.lat);
                    chk("goml_width", goml_len, 1);
                    chk("re_en_cycles", re_cnt, e.re_cycles);
                    chk("err_cnt", int'(err_cnt), e.cnt);
                    chk("viol", int'(viol), e.viol);
                end
            end
            goml_prev = goml;
            rreq_prev = rreq;
        end
    end

    // Directed stimulus.
    initial begin
        int snap;
        rst = 1'b0; lreq = 1'b0; rack = 1'b0; err1 = 1'b0; err0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lack", int'(lack), 0);
        chk("rst_rreq", int'(rreq), 0);
        chk("rst_re_en", int'(re_en), 0);
        chk("rst_goml", int'(goml), 0);
        chk("rst_viol", int'(viol), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst = 1'b1;
        @(negedge clk);

        // clean, error, unresolved-then-clean, stray rack during DELAY
        token(1'b0, 1'b1, 0, 1'b0, 1'b0, 6,  1, 0, 0);
        token(1'b1, 1'b0, 0, 1'b0, 1'b0, 8,  1, 1, 0);
        token(1'b0, 1'b1, 5, 1'b0, 1'b0, 11, 6, 1, 0);
        token(1'b0, 1'b1, 0, 1'b1, 1'b0, 6,  1, 1, 1);

        // lreq held high after completion must not start a second token
        snap = goml_total;
        token(1'b0, 1'b1, 0, 1'b0, 1'b1, 6, 1, 1, 1);
        repeat (10) @(negedge clk);
        chk("no_retrigger_goml_count", goml_total, snap + 1);
        chk("lack_held_with_lreq", int'(lack), 1);
        chk("idle_with_lreq_held", int'(busy), 0);
        lreq = 1'b0;
        wait_for(0, 1'b0, "lack_fall_held");

        // both rails set counts as an error; then saturation of the 2-bit counter
        token(1'b1, 1'b1, 0, 1'b0, 1'b0, 8, 1, 2, 1);
        token(1'b1, 1'b0, 0, 1'b0, 1'b0, 8, 1, 3, 1);
        token(1'b1, 1'b0, 0, 1'b0, 1'b0, 8, 1, 3, 1);
        token(1'b1, 1'b0, 0, 1'b0, 1'b0, 8, 1, 3, 1);

        // asynchronous reset two cycles after goml, mid-DELAY
        @(negedge clk);
        lreq = 1'b1; err0 = 1'b1;
        wait_for(3, 1'b1, "goml_before_reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("busy_before_reset", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("midrst_lack", int'(lack), 0);
        chk("midrst_rreq", int'(rreq), 0);
        chk("midrst_re_en", int'(re_en), 0);
        chk("midrst_goml", int'(goml), 0);
        chk("midrst_viol", int'(viol), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        lreq = 1'b0; err0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        token(1'b0, 1'b1, 0, 1'b0, 1'b0, 6, 1, 0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
